stack_ctrl: RTL
===============

STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the width of each stack word.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 2, meaning the stack pointer width; depth is 2**ADDR_WIDTH words.
REQ-003 The block SHALL have port control_clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port push_req, input, 1 bit: request to push data_in, sampled in IDLE only.
REQ-006 The block SHALL have port pop_req, input, 1 bit: request to pop the top word, sampled in IDLE only.
REQ-007 The block SHALL have port data_in, input, DATA_WIDTH bits: push data, captured on the cycle a push is accepted.
REQ-008 The block SHALL have port data_out, output, DATA_WIDTH bits: last popped word, held until the next pop completes.
REQ-009 The block SHALL have port data_valid, output, 1 bit: one-cycle pulse when data_out is updated.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-011 The block SHALL have port stack_ptr, output, ADDR_WIDTH+1 bits: current word count, range 0..2**ADDR_WIDTH.
REQ-012 The block SHALL have ports full_flag and empty_flag, output, 1 bit each: combinational decodes of stack_ptr.
REQ-013 The block SHALL have ports overflow_flag and underflow_flag, output, 1 bit each: one-cycle error pulses.

Function
REQ-014 Storage SHALL be an internal register array of 2**ADDR_WIDTH words of DATA_WIDTH bits.
REQ-015 The FSM SHALL have states IDLE, WRITE, READ and OUTPUT.
REQ-016 In IDLE with push_req=1 and full_flag=0, the block SHALL latch data_in and go to WRITE.
REQ-017 In WRITE, the block SHALL write the latched word to mem[stack_ptr], increment stack_ptr, and return to IDLE, giving a push latency of 2 cycles request-to-IDLE.
REQ-018 In IDLE with pop_req=1, push_req=0 and empty_flag=0, the block SHALL go to READ.
REQ-019 In READ, the block SHALL decrement stack_ptr and go to OUTPUT.
REQ-020 In OUTPUT, the block SHALL load data_out with mem[stack_ptr], pulse data_valid for one cycle, and return to IDLE, giving a pop latency of 3 cycles.
REQ-021 When push_req and pop_req are both 1 in IDLE, push SHALL take priority and pop_req SHALL be ignored for that cycle.
REQ-022 A push request while full_flag=1 SHALL perform no write, leave stack_ptr unchanged, pulse overflow_flag for one cycle, and remain in IDLE.
REQ-023 A pop request while empty_flag=1 (and push_req=0) SHALL leave stack_ptr and data_out unchanged, pulse underflow_flag for one cycle, and remain in IDLE.
REQ-024 full_flag SHALL equal (stack_ptr == 2**ADDR_WIDTH) and empty_flag SHALL equal (stack_ptr == 0).
REQ-025 stack_ptr SHALL never wrap; the rules in REQ-022 and REQ-023 are the only behaviour at the boundaries.
REQ-026 Requests asserted while busy=1 SHALL be ignored and SHALL NOT be queued.

Reset
REQ-027 While reset=0, the block SHALL asynchronously force state to IDLE, stack_ptr=0, data_out=0, and data_valid, overflow_flag and underflow_flag to 0.
REQ-028 Reset SHALL NOT be required to clear the memory array contents.
REQ-029 Reset asserted mid-operation (WRITE, READ or OUTPUT) SHALL abort the operation; no data_valid pulse SHALL be produced for it.
REQ-030 The first rising edge after reset deasserts SHALL be treated as IDLE.

Verification
REQ-031 Push 0x11, 0x22 and 0x33, then pop three times: data_out SHALL be 0x33, 0x22, 0x11, each with a single data_valid pulse, and stack_ptr SHALL step 1,2,3,2,1,0.
REQ-032 With ADDR_WIDTH=2, push four words, then a fifth: full_flag=1 after the fourth, and the fifth SHALL pulse overflow_flag, keep stack_ptr=4, and a following pop SHALL return the fourth word.
REQ-033 Pop from empty after reset: underflow_flag SHALL pulse once, data_out SHALL stay 0x00 and data_valid SHALL stay 0.
REQ-034 Assert push_req=1 and pop_req=1 together in IDLE with stack_ptr=1: a push SHALL occur (stack_ptr=2) and no pop.
REQ-035 Assert push_req during READ: the request SHALL be ignored, and the pop SHALL complete with the correct word.
REQ-036 Drive reset=0 during OUTPUT: all outputs SHALL clear immediately, with no data_valid pulse, and stack_ptr=0 after release.

Source files
------------

// File: rtl/stack_ctrl.sv
// ---------------------------------------------------------------------------
// stack_ctrl
//   LIFO stack controller with a four-state FSM (IDLE/WRITE/READ/OUTPUT)
//   wrapped around an internal register array of 2**ADDR_WIDTH words.
//   Push latency: 2 cycles from request to IDLE.
//   Pop latency:  3 cycles from request to data_valid.
//   Requests are sampled only in IDLE. They are never queued while busy.
//
// Ports
//   control_clock  : single clock, rising edge
//   reset          : asynchronous, active-low reset
//   push_req       : push data_in (sampled in IDLE only, wins over pop_req)
//   pop_req        : pop the top word (sampled in IDLE only)
//   data_in        : push data, captured when the push is accepted
//   data_out       : last popped word, held until the next pop completes
//   data_valid     : one-cycle pulse when data_out is updated
//   busy           : FSM is not in IDLE
//   stack_ptr      : current word count, 0..2**ADDR_WIDTH
//   full_flag      : stack_ptr == 2**ADDR_WIDTH
//   empty_flag     : stack_ptr == 0
//   overflow_flag  : one-cycle pulse, push rejected because stack is full
//   underflow_flag : one-cycle pulse, pop rejected because stack is empty
// ---------------------------------------------------------------------------
module stack_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                  control_clock,
   input  logic                  reset,
   input  logic                  push_req,
   input  logic                  pop_req,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  busy,
   output logic [ADDR_WIDTH:0]   stack_ptr,
   output logic                  full_flag,
   output logic                  empty_flag,
   output logic                  overflow_flag,
   output logic                  underflow_flag
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      READ   = 2'd2,
      OUTPUT = 2'd3
   } state_t;

   // The pointer is one bit wider than the address so that a full stack
   // (count == depth) is distinguishable from an empty one.
   localparam logic [ADDR_WIDTH:0] PTR_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] PTR_ZERO = '0;
   localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_t                  state_q,      state_d;
   logic [ADDR_WIDTH:0]     ptr_q,        ptr_d;
   logic [DATA_WIDTH-1:0]   data_out_q,   data_out_d;
   logic                    data_valid_q, data_valid_d;
   logic                    ovf_q,        ovf_d;
   logic                    udf_q,        udf_d;
   logic [DATA_WIDTH-1:0]   wdata_q,      wdata_d;
   logic                    mem_we;
   logic                    full_w;
   logic                    empty_w;

   logic [DATA_WIDTH-1:0]   mem_q [2**ADDR_WIDTH];

   assign full_w  = (ptr_q == PTR_FULL);
   assign empty_w = (ptr_q == PTR_ZERO);

   // ------------------------------------------------------------------
   // Next-state and datapath control
   // ------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      data_out_d   = data_out_q;
      wdata_d      = wdata_q;
      data_valid_d = 1'b0;
      ovf_d        = 1'b0;
      udf_d        = 1'b0;
      mem_we       = 1'b0;

      case (state_q)
         IDLE: begin
            // Push wins over pop when both are requested in the same cycle.
            if (push_req) begin
               if (full_w) begin
                  ovf_d = 1'b1;
               end else begin
                  wdata_d = data_in;
                  state_d = WRITE;
               end
            end else if (pop_req) begin
               if (empty_w) begin
                  udf_d = 1'b1;
               end else begin
                  state_d = READ;
               end
            end
         end
         WRITE: begin
            // ptr_q < depth here, so the low address bits index the array.
            mem_we  = 1'b1;
            ptr_d   = ptr_q + PTR_ONE;
            state_d = IDLE;
         end
         READ: begin
            ptr_d   = ptr_q - PTR_ONE;
            state_d = OUTPUT;
         end
         OUTPUT: begin
            // ptr_q was already decremented in READ and now points at the top word.
            data_out_d   = mem_q[ptr_q[ADDR_WIDTH-1:0]];
            data_valid_d = 1'b1;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Control and output registers (asynchronous active-low reset)
   // ------------------------------------------------------------------
   always_ff @(posedge control_clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         ptr_q        <= PTR_ZERO;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         ovf_q        <= 1'b0;
         udf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         ovf_q        <= ovf_d;
         udf_q        <= udf_d;
      end
   end

   // ------------------------------------------------------------------
   // Storage: the array and write holding register are not reset. The
   // write enable is only active in WRITE, which reset forces away, so a
   // reset mid-operation cannot corrupt the array.
   // ------------------------------------------------------------------
   always_ff @(posedge control_clock) begin
      wdata_q <= wdata_d;
      if (mem_we) begin
         mem_q[ptr_q[ADDR_WIDTH-1:0]] <= wdata_q;
      end
   end

   assign data_out       = data_out_q;
   assign data_valid     = data_valid_q;
   assign busy           = (state_q != IDLE);
   assign stack_ptr      = ptr_q;
   assign full_flag      = full_w;
   assign empty_flag     = empty_w;
   assign overflow_flag  = ovf_q;
   assign underflow_flag = udf_q;

endmodule
